// File: rtl/multiciclo_control.sv
// Control FSM for a multi-cycle RV32I datapath: one instruction is stepped
// through fetch/decode/execute/memory/writeback using a req/ready memory handshake.
module multiciclo_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_wr,
  output logic       pc_wr,
  output logic       pc_src,
  output logic [1:0] alu_a_src,
  output logic [1:0] alu_b_src,
  output logic [3:0] alu_op,
  output logic [2:0] imm_src,
  output logic [4:0] br_op,
  output logic [2:0] dm_ctrl,
  output logic [1:0] result_src,
  output logic       ru_wr,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,  DECODE = 4'd1,  EXEC_R = 4'd2,  EXEC_I  = 4'd3,
    ALU_WB   = 4'd4,  MEM_ADDR = 4'd5, MEM_RD = 4'd6, MEM_WB  = 4'd7,
    MEM_WR   = 4'd8,  BRANCH = 4'd9,  JAL    = 4'd10, JALR    = 4'd11,
    LUI      = 4'd12, AUIPC  = 4'd13, ILLEGAL = 4'd14
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  state_t state, nextState;
  logic   illegalQ;
  logic   memReqRaw, memWeRaw, irWrRaw, pcWrRaw, ruWrRaw;

  // Only funct7[5] distinguishes RV32I operations.
  logic unusedFunct7;
  assign unusedFunct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    nextState = state;
    case (state)
      FETCH:  if (mem_ready) nextState = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:              nextState = EXEC_R;
          OP_I:              nextState = EXEC_I;
          OP_LOAD, OP_STORE: nextState = MEM_ADDR;
          OP_BR:             nextState = BRANCH;
          OP_JAL:            nextState = JAL;
          OP_JALR:           nextState = JALR;
          OP_LUI:            nextState = LUI;
          OP_AUIPC:          nextState = AUIPC;
          default:           nextState = ILLEGAL;
        endcase
      end
      EXEC_R, EXEC_I: nextState = ALU_WB;
      MEM_ADDR:       nextState = opcode[5] ? MEM_WR : MEM_RD;
      MEM_RD:         if (mem_ready) nextState = MEM_WB;
      MEM_WR:         if (mem_ready) nextState = FETCH;
      ILLEGAL:        nextState = ILLEGAL;
      default:        nextState = FETCH;
    endcase
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    memReqRaw  = 1'b0;
    memWeRaw   = 1'b0;
    irWrRaw    = 1'b0;
    pcWrRaw    = 1'b0;
    ruWrRaw    = 1'b0;
    iord       = 1'b0;
    pc_src     = 1'b0;
    alu_a_src  = 2'b00;
    alu_b_src  = 2'b00;
    alu_op     = 4'b0000;
    imm_src    = 3'b000;
    br_op      = 5'b00000;
    dm_ctrl    = 3'b000;
    result_src = 2'b00;
    case (state)
      FETCH: begin
        memReqRaw = 1'b1;
        if (mem_ready) begin
          irWrRaw   = 1'b1;
          pcWrRaw   = 1'b1;
          alu_b_src = 2'b10;
        end
      end
      DECODE: begin
        // ALUOut captures oldPC + B-immediate as a speculative branch target.
        alu_a_src = 2'b01;
        alu_b_src = 2'b01;
        imm_src   = 3'b101;
      end
      EXEC_R: begin
        alu_a_src = 2'b10;
        alu_op    = {funct7[5], funct3};
      end
      EXEC_I: begin
        // funct7[5] is immediate bits for everything but shift-right.
        alu_a_src = 2'b10;
        alu_b_src = 2'b01;
        alu_op    = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
      end
      ALU_WB: ruWrRaw = 1'b1;
      MEM_ADDR: begin
        alu_a_src = 2'b10;
        alu_b_src = 2'b01;
        imm_src   = opcode[5] ? 3'b001 : 3'b000;
      end
      MEM_RD: begin
        memReqRaw = 1'b1;
        iord      = 1'b1;
        dm_ctrl   = funct3;
      end
      MEM_WB: begin
        ruWrRaw    = 1'b1;
        result_src = 2'b01;
        dm_ctrl    = funct3;
      end
      MEM_WR: begin
        memReqRaw = 1'b1;
        memWeRaw  = 1'b1;
        iord      = 1'b1;
        dm_ctrl   = funct3;
      end
      BRANCH: begin
        br_op = {2'b01, funct3};
        if (br_taken) begin
          pcWrRaw = 1'b1;
          pc_src  = 1'b1;
        end
      end
      JAL, JALR: begin
        // rd takes the already-incremented PC, i.e. oldPC + 4.
        alu_a_src  = (state == JALR) ? 2'b10 : 2'b01;
        alu_b_src  = 2'b01;
        imm_src    = (state == JALR) ? 3'b000 : 3'b110;
        pcWrRaw    = 1'b1;
        ruWrRaw    = 1'b1;
        result_src = 2'b11;
      end
      LUI: begin
        alu_b_src  = 2'b01;
        imm_src    = 3'b010;
        alu_op     = 4'b1111;
        result_src = 2'b10;
        ruWrRaw    = 1'b1;
      end
      AUIPC: begin
        alu_a_src  = 2'b01;
        alu_b_src  = 2'b01;
        imm_src    = 3'b010;
        result_src = 2'b10;
        ruWrRaw    = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are masked by reset combinationally so a pending access aborts at once.
  assign mem_req   = memReqRaw & rst_n;
  assign mem_we    = memWeRaw  & rst_n;
  assign ir_wr     = irWrRaw   & rst_n;
  assign pc_wr     = pcWrRaw   & rst_n;
  assign ru_wr     = ruWrRaw   & rst_n;
  assign illegal   = illegalQ;
  assign state_dbg = state;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH;
      illegalQ <= 1'b0;
    end else begin
      state <= nextState;
      if (nextState == ILLEGAL) illegalQ <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multiciclo_control.sv
// Scoreboard bench for multiciclo_control: directed per-cycle expectations are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_multiciclo_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       br_taken, mem_ready;
  logic       mem_req, mem_we, iord, ir_wr, pc_wr, pc_src, ru_wr, illegal;
  logic [1:0] alu_a_src, alu_b_src, result_src;
  logic [3:0] alu_op, state_dbg;
  logic [2:0] imm_src, dm_ctrl;
  logic [4:0] br_op;

  multiciclo_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_taken(br_taken), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .iord(iord), .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src),
    .alu_a_src(alu_a_src), .alu_b_src(alu_b_src), .alu_op(alu_op),
    .imm_src(imm_src), .br_op(br_op), .dm_ctrl(dm_ctrl), .result_src(result_src),
    .ru_wr(ru_wr), .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3, S_ALU_WB = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6,
    S_MEM_WB = 4'd7, S_MEM_WR = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10,
    S_JALR = 4'd11, S_LUI = 4'd12, S_AUIPC = 4'd13, S_ILLEGAL = 4'd14;

  // Strobe order in expectations: {mem_req, mem_we, ir_wr, pc_wr, ru_wr}.
  typedef struct packed {
    logic [3:0] st;
    logic [4:0] stb;
    logic       io, ps;
    logic [1:0] aSrc, bSrc;
    logic [3:0] aluOp;
    logic [2:0] imm;
    logic [4:0] br;
    logic [2:0] dm;
    logic [1:0] res;
    logic       ill;
  } obs_t;

  typedef struct {
    string name;
    obs_t  e;
    obs_t  m;
  } item_t;

  item_t sbQ[$];
  item_t it;
  int    checks = 0;
  int    errors = 0;

  // Monitor: pops one expectation per cycle and compares the cared-for fields.
  initial begin
    forever begin
      @(negedge clk);
      if (sbQ.size() > 0) begin
        item_t x;
        obs_t  o;
        x = sbQ.pop_front();
        o = {state_dbg, mem_req, mem_we, ir_wr, pc_wr, ru_wr, iord, pc_src,
             alu_a_src, alu_b_src, alu_op, imm_src, br_op, dm_ctrl, result_src, illegal};
        checks++;
        if (((o ^ x.e) & x.m) != '0) begin
          errors++;
          $display("FAIL %s @%0t: actual %h required %h (care mask %h)",
                   x.name, $time, o, x.e, x.m);
        end
      end
    end
  end

  task automatic nw(input string name, input logic [3:0] st, input logic [4:0] stb);
    it.name = name;
    it.e = '0;
    it.m = '0;
    it.e.st = st;  it.m.st = '1;
    it.e.stb = stb; it.m.stb = '1;
    it.m.ill = 1'b1;
  endtask

  task automatic fA(input logic [1:0] v);  it.e.aSrc = v;  it.m.aSrc = '1;  endtask
  task automatic fB(input logic [1:0] v);  it.e.bSrc = v;  it.m.bSrc = '1;  endtask
  task automatic fOp(input logic [3:0] v); it.e.aluOp = v; it.m.aluOp = '1; endtask
  task automatic fImm(input logic [2:0] v); it.e.imm = v;  it.m.imm = '1;   endtask
  task automatic fBr(input logic [4:0] v); it.e.br = v;    it.m.br = '1;    endtask
  task automatic fDm(input logic [2:0] v); it.e.dm = v;    it.m.dm = '1;    endtask
  task automatic fRes(input logic [1:0] v); it.e.res = v;  it.m.res = '1;   endtask
  task automatic fIo(input logic v);       it.e.io = v;    it.m.io = 1'b1;  endtask
  task automatic fPs(input logic v);       it.e.ps = v;    it.m.ps = 1'b1;  endtask
  task automatic fIll(input logic v);      it.e.ill = v;                    endtask

  task automatic go(input logic rst, input logic rdy, input logic bt);
    rst_n     = rst;
    mem_ready = rdy;
    br_taken  = bt;
    sbQ.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic setIns(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
  endtask

  task automatic fetchWait();
    nw("fetch_wait", S_FETCH, 5'b10000); fIo(1'b0);
    go(1'b1, 1'b0, 1'b0);
  endtask

  task automatic fetchOk();
    nw("fetch", S_FETCH, 5'b10110);
    fIo(1'b0); fA(2'b00); fB(2'b10); fOp(4'b0000); fPs(1'b0);
    go(1'b1, 1'b1, 1'b0);
  endtask

  task automatic decode();
    nw("decode", S_DECODE, 5'b00000);
    fA(2'b01); fB(2'b01); fImm(3'b101); fOp(4'b0000);
    go(1'b1, 1'b1, 1'b0);
  endtask

  task automatic aluWb();
    nw("alu_wb", S_ALU_WB, 5'b00001); fRes(2'b00);
    go(1'b1, 1'b1, 1'b0);
  endtask

  task automatic execI(input string name, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [3:0] op);
    setIns(7'b0010011, f3, f7);
    fetchOk(); decode();
    nw(name, S_EXEC_I, 5'b00000); fA(2'b10); fB(2'b01); fImm(3'b000); fOp(op);
    go(1'b1, 1'b1, 1'b0);
    aluWb();
  endtask

  task automatic branch(input logic bt);
    setIns(7'b1100011, 3'b000, 7'b0000000);
    fetchOk(); decode();
    nw(bt ? "beq_taken" : "beq_not_taken", S_BRANCH, bt ? 5'b00010 : 5'b00000);
    fBr(5'b01000);
    if (bt) fPs(1'b1);
    go(1'b1, 1'b1, bt);
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; br_taken = 1'b0;
    setIns(7'b0110011, 3'b000, 7'b0000000);
    @(posedge clk); #1;

    // Reset cycle: strobes held low even though the FSM is in FETCH with ready high.
    nw("reset", S_FETCH, 5'b00000);
    go(1'b0, 1'b1, 1'b0);

    // add x3,x1,x2
    setIns(7'b0110011, 3'b000, 7'b0000000);
    fetchOk(); decode();
    nw("add_exec", S_EXEC_R, 5'b00000); fA(2'b10); fB(2'b00); fOp(4'b0000);
    go(1'b1, 1'b1, 1'b0);
    aluWb();

    // sub
    setIns(7'b0110011, 3'b000, 7'b0100000);
    fetchOk(); decode();
    nw("sub_exec", S_EXEC_R, 5'b00000); fA(2'b10); fB(2'b00); fOp(4'b1000);
    go(1'b1, 1'b1, 1'b0);
    aluWb();

    execI("srai_exec", 3'b101, 7'b0100000, 4'b1101);
    execI("srli_exec", 3'b101, 7'b0000000, 4'b0101);
    // addi with immediate bit 30 set must still be an add.
    execI("addi_exec", 3'b000, 7'b0100000, 4'b0000);

    // lw with 2 fetch wait cycles and 3 memory wait cycles: 10 cycles total.
    setIns(7'b0000011, 3'b010, 7'b0000000);
    fetchWait(); fetchWait(); fetchOk(); decode();
    nw("lw_addr", S_MEM_ADDR, 5'b00000); fA(2'b10); fB(2'b01); fImm(3'b000); fOp(4'b0000);
    go(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nw("lw_rd_wait", S_MEM_RD, 5'b10000); fIo(1'b1); fDm(3'b010);
      go(1'b1, 1'b0, 1'b0);
    end
    nw("lw_rd", S_MEM_RD, 5'b10000); fIo(1'b1); fDm(3'b010);
    go(1'b1, 1'b1, 1'b0);
    nw("lw_wb", S_MEM_WB, 5'b00001); fRes(2'b01); fDm(3'b010);
    go(1'b1, 1'b1, 1'b0);

    // sw with zero-wait memory: 4 cycles, one write strobe.
    setIns(7'b0100011, 3'b010, 7'b0000000);
    fetchOk(); decode();
    nw("sw_addr", S_MEM_ADDR, 5'b00000); fA(2'b10); fB(2'b01); fImm(3'b001);
    go(1'b1, 1'b1, 1'b0);
    nw("sw_wr", S_MEM_WR, 5'b11000); fIo(1'b1); fDm(3'b010);
    go(1'b1, 1'b1, 1'b0);

    branch(1'b1);
    branch(1'b0);

    setIns(7'b1101111, 3'b000, 7'b0000000);
    fetchOk(); decode();
    nw("jal", S_JAL, 5'b00011);
    fA(2'b01); fB(2'b01); fImm(3'b110); fOp(4'b0000); fPs(1'b0); fRes(2'b11);
    go(1'b1, 1'b1, 1'b0);

    setIns(7'b1100111, 3'b000, 7'b0000000);
    fetchOk(); decode();
    nw("jalr", S_JALR, 5'b00011);
    fA(2'b10); fB(2'b01); fImm(3'b000); fOp(4'b0000); fPs(1'b0); fRes(2'b11);
    go(1'b1, 1'b1, 1'b0);

    setIns(7'b0110111, 3'b000, 7'b0000000);
    fetchOk(); decode();
    nw("lui", S_LUI, 5'b00001); fB(2'b01); fImm(3'b010); fOp(4'b1111); fRes(2'b10);
    go(1'b1, 1'b1, 1'b0);

    setIns(7'b0010111, 3'b000, 7'b0000000);
    fetchOk(); decode();
    nw("auipc", S_AUIPC, 5'b00001);
    fA(2'b01); fB(2'b01); fImm(3'b010); fOp(4'b0000); fRes(2'b10);
    go(1'b1, 1'b1, 1'b0);

    // Illegal opcode: trapped with no strobes regardless of ready/taken.
    setIns(7'b0000000, 3'b000, 7'b0000000);
    fetchOk(); decode();
    for (int i = 0; i < 20; i++) begin
      nw("illegal_hold", S_ILLEGAL, 5'b00000); fIll(1'b1);
      go(1'b1, 1'(i % 2), 1'(i % 3 == 0));
    end
    nw("illegal_in_reset", S_ILLEGAL, 5'b00000); fIll(1'b1);
    go(1'b0, 1'b1, 1'b0);
    nw("illegal_cleared", S_FETCH, 5'b10000); fIo(1'b0);
    go(1'b1, 1'b0, 1'b0);
    fetchOk();

    // Reset while a store waits: request and write drop immediately.
    setIns(7'b0100011, 3'b000, 7'b0000000);
    decode();
    nw("sw_addr2", S_MEM_ADDR, 5'b00000); fImm(3'b001);
    go(1'b1, 1'b1, 1'b0);
    nw("sw_wait", S_MEM_WR, 5'b11000); fIo(1'b1); fDm(3'b000);
    go(1'b1, 1'b0, 1'b0);
    nw("sw_abort", S_MEM_WR, 5'b00000);
    go(1'b0, 1'b0, 1'b0);
    nw("after_abort", S_FETCH, 5'b10000); fIo(1'b0);
    go(1'b1, 1'b0, 1'b0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && sbQ.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sbQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
